// File: rtl/prog_loader.sv
// Switch-entry program loader: each debounced key press writes switch value D
// to the RAM at an auto-incrementing address while program-load mode is active.
module prog_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic [7:0]  START_ADDR      = 8'h00,
   parameter logic [7:0]  LAST_ADDR       = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       key,
   input  logic       clear,
   input  logic [7:0] D,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] ptr,
   output logic       full,
   output logic       busy
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      ARMED       = 3'd1,
      DEB_PRESS   = 3'd2,
      WRITE       = 3'd3,
      DEB_RELEASE = 3'd4,
      FULL        = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             key_s_q, key_s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_en_q, wr_en_d;
   logic [7:0]       wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic [7:0]       ptr_q, ptr_d;
   logic             full_q, full_d;
   logic             busy_q, busy_d;

   // Next-state, pointer and output computation.
   always_comb begin
      state_d   = state_q;
      sync1_d   = key;
      key_s_d   = sync1_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ptr_d     = ptr_q;
      full_d    = full_q;

      // Pointer advances (or saturates) on the edge that ends the write cycle.
      if (state_q == WRITE) begin
         if (ptr_q == LAST_ADDR) begin
            full_d = 1'b1;
         end else begin
            ptr_d = ptr_q + 8'd1;
         end
      end

      // Clear wins over the post-write increment.
      if (clear) begin
         ptr_d  = START_ADDR;
         full_d = 1'b0;
      end

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = full_d ? FULL : ARMED;
            end
            ARMED: begin
               if (key_s_q) begin
                  if (CNT_ONE >= CNT_MAX) begin
                     state_d   = WRITE;
                     cnt_d     = '0;
                     wr_en_d   = 1'b1;
                     wr_addr_d = ptr_q;
                     wr_data_d = D;
                  end else begin
                     state_d = DEB_PRESS;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            DEB_PRESS: begin
               if (!key_s_q) begin
                  state_d = ARMED;
                  cnt_d   = '0;
               end else if (cnt_q + CNT_ONE >= CNT_MAX) begin
                  state_d   = WRITE;
                  cnt_d     = '0;
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = D;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            WRITE: begin
               state_d = DEB_RELEASE;
               cnt_d   = '0;
            end
            DEB_RELEASE: begin
               if (key_s_q) begin
                  cnt_d = '0;
               end else if (cnt_q + CNT_ONE >= CNT_MAX) begin
                  cnt_d   = '0;
                  state_d = full_d ? FULL : ARMED;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            FULL: begin
               // Re-arm through release debounce so a held key cannot write at once.
               if (clear) begin
                  state_d = DEB_RELEASE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      busy_d = (state_d == DEB_PRESS) || (state_d == WRITE) || (state_d == DEB_RELEASE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b0;
         key_s_q   <= 1'b0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         ptr_q     <= START_ADDR;
         full_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         key_s_q   <= key_s_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ptr_q     <= ptr_d;
         full_q    <= full_d;
         busy_q    <= busy_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign ptr     = ptr_q;
   assign full    = full_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (default and top-of-memory address range)
// share stimulus; a press-level model predicts writes, pointer and full flag.
module tb_prog_loader;

   localparam int unsigned N = 4;

   typedef struct {
      int         d;
      logic [7:0] a;
      logic [7:0] v;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst, en, key, clear;
   logic [7:0] D;

   logic       wr_en_a, full_a, busy_a;
   logic [7:0] wr_addr_a, wr_data_a, ptr_a;
   logic       wr_en_b, full_b, busy_b;
   logic [7:0] wr_addr_b, wr_data_b, ptr_b;

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   wr_t        wq[$];
   logic [7:0] m_ptr[2];
   logic       m_full[2];

   prog_loader #(.DEBOUNCE_CYCLES(N), .START_ADDR(8'h00), .LAST_ADDR(8'hFF)) dut_a (
      .clk(clk), .rst(rst), .en(en), .key(key), .clear(clear), .D(D),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .ptr(ptr_a), .full(full_a), .busy(busy_a));

   prog_loader #(.DEBOUNCE_CYCLES(N), .START_ADDR(8'hFE), .LAST_ADDR(8'hFF)) dut_b (
      .clk(clk), .rst(rst), .en(en), .key(key), .clear(clear), .D(D),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .ptr(ptr_b), .full(full_b), .busy(busy_b));

   always #5 clk = ~clk;

   // Record every RAM write strobe of both instances.
   always @(negedge clk) begin
      if (wr_en_a === 1'b1) wq.push_back('{0, wr_addr_a, wr_data_a});
      if (wr_en_b === 1'b1) wq.push_back('{1, wr_addr_b, wr_data_b});
   end

   function automatic int nw(input int d);
      int n = 0;
      foreach (wq[i]) if (wq[i].d == d) n++;
      return n;
   endfunction

   function automatic wr_t first_wr(input int d);
      wr_t w = '{-1, 8'h00, 8'h00};
      for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].d == d) w = wq[i];
      return w;
   endfunction

   // A clean press writes to the next address unless memory is already full.
   function automatic logic model_press(input int d, output logic [7:0] a);
      a = m_ptr[d];
      if (m_full[d]) return 1'b0;
      if (m_ptr[d] == 8'hFF) m_full[d] = 1'b1;
      else m_ptr[d] = m_ptr[d] + 8'd1;
      return 1'b1;
   endfunction

   task automatic restart();
      rst = 1'b1; en = 1'b0; key = 1'b0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      wq.delete();
      m_ptr[0] = 8'h00; m_ptr[1] = 8'hFE;
      m_full[0] = 1'b0; m_full[1] = 1'b0;
   endtask

   task automatic press(input int hold, input logic [7:0] val, input logic chg);
      D = val;
      @(posedge clk); #1 key = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         if (chg && (wr_en_a || wr_en_b)) D = 8'($urandom);
      end
      key = 1'b0;
      repeat (N + 8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; key = 1'b0; clear = 1'b0; D = 8'hA5;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if ({wr_en_a, wr_addr_a, wr_data_a, full_a, busy_a} !== 19'd0)
         $display("FAIL reset_outs: got %0h expected 0", {wr_en_a, wr_addr_a, wr_data_a, full_a, busy_a});
      else pass_cnt++;
      total_cnt++;
      if (ptr_a !== 8'h00) $display("FAIL reset_ptr_a: got %0h expected 00", ptr_a);
      else pass_cnt++;
      total_cnt++;
      if (ptr_b !== 8'hFE) $display("FAIL reset_ptr_b: got %0h expected fe", ptr_b);
      else pass_cnt++;
   endtask

   task automatic test_single_press();
      int hits = 0;
      int idx = -1;
      logic [7:0] ga = 8'h00, gd = 8'h00, ea;
      logic busy_mid = 1'b0;
      void'(model_press(0, ea));
      restart();
      void'(model_press(0, ea));
      D = 8'h3C;
      key = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (wr_en_a) begin hits++; idx = i; ga = wr_addr_a; gd = wr_data_a; end
         if (i == 10) busy_mid = busy_a;
      end
      key = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      total_cnt++;
      if (hits !== 1) $display("FAIL single_count: got %0d expected 1", hits); else pass_cnt++;
      total_cnt++;
      if (idx !== int'(N) + 1) $display("FAIL single_latency: got %0d expected %0d", idx, N + 1); else pass_cnt++;
      total_cnt++;
      if (ga !== ea) $display("FAIL single_addr: got %0h expected %0h", ga, ea); else pass_cnt++;
      total_cnt++;
      if (gd !== 8'h3C) $display("FAIL single_data: got %0h expected 3c", gd); else pass_cnt++;
      total_cnt++;
      if (busy_mid !== 1'b1) $display("FAIL single_busy_held: got %0b expected 1", busy_mid); else pass_cnt++;
      total_cnt++;
      if (ptr_a !== m_ptr[0]) $display("FAIL single_ptr: got %0h expected %0h", ptr_a, m_ptr[0]); else pass_cnt++;
      total_cnt++;
      if (busy_a !== 1'b0) $display("FAIL single_busy_after: got %0b expected 0", busy_a); else pass_cnt++;
   endtask

   task automatic test_bounce();
      logic [7:0] ea;
      logic       ew;
      wr_t        w;
      restart();
      key = 1'b1; repeat (2) @(posedge clk); #1;
      key = 1'b0; repeat (1) @(posedge clk); #1;
      key = 1'b1; repeat (2) @(posedge clk); #1;
      key = 1'b0; repeat (2) @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
         key = 1'b1; repeat ($urandom_range(1, N - 1)) @(posedge clk); #1;
         key = 1'b0; repeat ($urandom_range(1, 3)) @(posedge clk); #1;
      end
      repeat (12) @(posedge clk);
      #1;
      total_cnt++;
      if (nw(0) !== 0) $display("FAIL bounce_writes: got %0d expected 0", nw(0)); else pass_cnt++;
      total_cnt++;
      if (ptr_a !== m_ptr[0]) $display("FAIL bounce_ptr: got %0h expected %0h", ptr_a, m_ptr[0]); else pass_cnt++;
      total_cnt++;
      if (busy_a !== 1'b0) $display("FAIL bounce_busy: got %0b expected 0", busy_a); else pass_cnt++;
      // Still armed: a clean press now goes through.
      ew = model_press(0, ea);
      press($urandom_range(8, 15), 8'h5A, 1'b0);
      w = first_wr(0);
      total_cnt++;
      if (nw(0) !== (ew ? 1 : 0) || w.a !== ea)
         $display("FAIL bounce_rearm: got %0d writes addr %0h expected 1 write addr %0h", nw(0), w.a, ea);
      else pass_cnt++;
   endtask

   task automatic test_sequence();
      restart();
      for (int k = 0; k < 6; k++) begin
         logic [7:0] v, ea;
         logic       ew;
         wr_t        w;
         v = (k < 3) ? 8'(8'h11 * (k + 1)) : 8'($urandom);
         wq.delete();
         ew = model_press(0, ea);
         press($urandom_range(8, 15), v, 1'b1);
         w = first_wr(0);
         total_cnt++;
         if (nw(0) !== (ew ? 1 : 0) || w.a !== ea || w.v !== v)
            $display("FAIL seq_write%0d: got n=%0d (%0h,%0h) expected n=1 (%0h,%0h)", k, nw(0), w.a, w.v, ea, v);
         else pass_cnt++;
      end
      total_cnt++;
      if (ptr_a !== m_ptr[0]) $display("FAIL seq_ptr: got %0h expected %0h", ptr_a, m_ptr[0]); else pass_cnt++;
   endtask

   task automatic test_full();
      restart();
      for (int k = 0; k < 3; k++) begin
         logic [7:0] v, ea;
         logic       ew;
         wr_t        w;
         v = 8'($urandom);
         wq.delete();
         ew = model_press(1, ea);
         press($urandom_range(8, 15), v, 1'b0);
         w = first_wr(1);
         total_cnt++;
         if (nw(1) !== (ew ? 1 : 0) || (ew && (w.a !== ea || w.v !== v)))
            $display("FAIL full_write%0d: got n=%0d (%0h,%0h) expected n=%0d (%0h,%0h)", k, nw(1), w.a, w.v, ew ? 1 : 0, ea, v);
         else pass_cnt++;
         total_cnt++;
         if (ptr_b !== m_ptr[1] || full_b !== m_full[1])
            $display("FAIL full_state%0d: got ptr=%0h full=%0b expected ptr=%0h full=%0b", k, ptr_b, full_b, m_ptr[1], m_full[1]);
         else pass_cnt++;
      end
   endtask

   task automatic test_clear_full();
      logic [7:0] v, ea;
      logic       ew;
      wr_t        w;
      wq.delete();
      key = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      total_cnt++;
      if (busy_b !== 1'b0) $display("FAIL clrfull_busy_full: got %0b expected 0", busy_b); else pass_cnt++;
      clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      m_ptr[1] = 8'hFE; m_full[1] = 1'b0;
      total_cnt++;
      if (ptr_b !== m_ptr[1] || full_b !== m_full[1])
         $display("FAIL clrfull_state: got ptr=%0h full=%0b expected ptr=%0h full=%0b", ptr_b, full_b, m_ptr[1], m_full[1]);
      else pass_cnt++;
      total_cnt++;
      if (busy_b !== 1'b1) $display("FAIL clrfull_busy_release: got %0b expected 1", busy_b); else pass_cnt++;
      repeat (10) @(posedge clk);
      #1 key = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      total_cnt++;
      if (nw(1) !== 0) $display("FAIL clrfull_held_writes: got %0d expected 0", nw(1)); else pass_cnt++;
      v = 8'($urandom);
      ew = model_press(1, ea);
      press($urandom_range(8, 15), v, 1'b0);
      w = first_wr(1);
      total_cnt++;
      if (nw(1) !== (ew ? 1 : 0) || w.a !== ea || w.v !== v)
         $display("FAIL clrfull_repress: got n=%0d (%0h,%0h) expected n=1 (%0h,%0h)", nw(1), w.a, w.v, ea, v);
      else pass_cnt++;
   endtask

   task automatic test_clear_in_write();
      logic [7:0] ea;
      logic       ew;
      wr_t        w;
      restart();
      void'(model_press(0, ea));
      press(10, 8'h77, 1'b0);
      wq.delete();
      ew = model_press(0, ea);
      D = 8'h99;
      @(posedge clk); #1 key = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (wr_en_a) break;
      end
      clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      m_ptr[0] = 8'h00; m_full[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1 key = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      w = first_wr(0);
      total_cnt++;
      if (nw(0) !== (ew ? 1 : 0) || w.a !== ea || w.v !== 8'h99)
         $display("FAIL clrwr_write: got n=%0d (%0h,%0h) expected n=1 (%0h,99)", nw(0), w.a, w.v, ea);
      else pass_cnt++;
      total_cnt++;
      if (ptr_a !== m_ptr[0]) $display("FAIL clrwr_ptr: got %0h expected %0h", ptr_a, m_ptr[0]); else pass_cnt++;
   endtask

   task automatic test_en_drop();
      logic [7:0] ea;
      restart();
      void'(model_press(0, ea));
      press(9, 8'hC3, 1'b0);
      wq.delete();
      key = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (busy_a !== 1'b1) $display("FAIL endrop_busy_deb: got %0b expected 1", busy_a); else pass_cnt++;
      en = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (busy_a !== 1'b0) $display("FAIL endrop_busy_idle: got %0b expected 0", busy_a); else pass_cnt++;
      repeat (10) @(posedge clk);
      #1 key = 1'b0;
      repeat (4) @(posedge clk);
      #1 en = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      total_cnt++;
      if (nw(0) !== 0) $display("FAIL endrop_writes: got %0d expected 0", nw(0)); else pass_cnt++;
      total_cnt++;
      if (ptr_a !== m_ptr[0]) $display("FAIL endrop_ptr: got %0h expected %0h", ptr_a, m_ptr[0]); else pass_cnt++;
   endtask

   task automatic test_rst_mid();
      wq.delete();
      key = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1; key = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      m_ptr[0] = 8'h00; m_full[0] = 1'b0;
      total_cnt++;
      if ({wr_en_a, wr_addr_a, wr_data_a, full_a, busy_a} !== 19'd0)
         $display("FAIL rstmid_outs: got %0h expected 0", {wr_en_a, wr_addr_a, wr_data_a, full_a, busy_a});
      else pass_cnt++;
      total_cnt++;
      if (ptr_a !== m_ptr[0]) $display("FAIL rstmid_ptr: got %0h expected %0h", ptr_a, m_ptr[0]); else pass_cnt++;
      repeat (12) @(posedge clk);
      #1;
      total_cnt++;
      if (nw(0) !== 0) $display("FAIL rstmid_writes: got %0d expected 0", nw(0)); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_sequence();
      test_full();
      test_clear_full();
      test_clear_in_write();
      test_en_drop();
      test_rst_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Switch-entry program loader sitting directly upstream of the `ram` block.
- While the CPU controller is in the load state, each debounced press of the load key writes the 8-bit switch value `D` into RAM at an auto-incrementing address.
- Its write port drives the RAM's write/address/data inputs.
- Its pointer and status outputs feed the `light_show` display.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a key level change (synthesis uses a large value).
- START_ADDR, 8'h00, address of the first write after reset or `clear`.
- LAST_ADDR, 8'hFF, highest writable address; the write to it sets `full`.

Ports:
- clk  in  1  system clock (the memory clock domain).
- rst  in  1  synchronous, active-high reset.
- en  in  1  high when cpustate selects program-load mode.
- key  in  1  raw, asynchronous, bouncy load button (active high).
- clear  in  1  synchronous pulse; rewinds the pointer.
- D  in  8  switch data to store.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  8  RAM write address.
- wr_data  out  8  RAM write data.
- ptr  out  8  next address to be written (for display).
- full  out  1  LAST_ADDR has been written.
- busy  out  1  a press is being debounced, written, or waiting for release.

Behaviour:

Reset (rst high at an edge):
- State becomes IDLE; sync flops and debounce counter 0.
- wr_en=0, wr_addr=0, wr_data=0, ptr=START_ADDR, full=0, busy=0.
- Reset mid-debounce or mid-write aborts with no write issued.

Synchronizer:
- key passes through two flops to give key_s; key_s is the only form of key used.
- A key rise sampled at edge E0 is visible as key_s=1 from edge E1.

States: IDLE, ARMED, DEB_PRESS, WRITE, DEB_RELEASE, FULL.
- IDLE: wait for en=1, then go to ARMED. If full=1 when en rises, go to FULL instead.
- ARMED: if key_s=1, go to DEB_PRESS with count=1.
- DEB_PRESS:
  - key_s=1: count increments.
  - key_s=0: return to ARMED, count=0, no write.
  - When count reaches DEBOUNCE_CYCLES, capture wr_data<=D, wr_addr<=ptr, and go to WRITE.
- WRITE: wr_en=1 for exactly this one cycle, then go to DEB_RELEASE. At the same edge:
  - if ptr==LAST_ADDR: full<=1 and ptr holds;
  - else ptr<=ptr+1.
- DEB_RELEASE:
  - Needs key_s=0 for DEBOUNCE_CYCLES consecutive cycles; any key_s=1 resets the count.
  - Then go to ARMED, or to FULL if full=1.
  - Holding the key therefore produces exactly one write.
- FULL: presses are ignored and no wr_en is issued.

Latency:
- Key stable high from E0 with N=DEBOUNCE_CYCLES: key_s is sampled high at edges E1..EN.
- wr_en is high in the cycle between E(N+1) and E(N+2).

Address and data rules:
- wr_data is D sampled at the acceptance edge; later D changes do not affect the write.
- ptr never wraps: the LAST_ADDR write saturates ptr and sets full.

clear:
- Next edge: ptr<=START_ADDR, full<=0.
- If in FULL, go to DEB_RELEASE so a still-held key cannot cause an immediate write.
- clear in the same cycle as WRITE: the write completes to the captured address, then ptr=START_ADDR (clear wins over increment).

en deasserted in any state:
- Next edge: go to IDLE, counters cleared, wr_en=0.
- ptr and full are held.
- A write already in its WRITE cycle completes.

Outputs:
- busy=1 in DEB_PRESS, WRITE and DEB_RELEASE; 0 otherwise.
- All outputs are registered; no combinational path from key or D to wr_en.

Test Plan:
1. rst for 2 cycles, en=1, D=8'h3C, key high for 20 cycles then low → exactly one wr_en pulse, with wr_addr=00 and wr_data=3C, in the cycle after the 5th edge following the key rise; afterwards ptr=01 and busy returns to 0 after release debounce.
2. Bounce: key high 2 cycles, low 1, high 2, low (N=4) → no wr_en, state back to ARMED, ptr unchanged at 00.
3. Three clean presses with D=11, 22, 33, changing D right after each acceptance → writes (00,11), (01,22), (02,33); ptr=03.
4. START_ADDR=FE, LAST_ADDR=FF; three presses → writes to FE and FF only; full=1 after the second; the third press yields no wr_en; ptr stays FF.
5. From full, pulse clear while the key is held → ptr=FE, full=0, no write until the key is released and pressed again.
6. Drop en during DEB_PRESS, and assert rst during DEB_PRESS in a separate run → no wr_en; en case holds ptr; rst case gives ptr=START_ADDR and all outputs 0.
